// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory: core request/response structs,
// controller state encoding and byte-lane helper.
package data_mem_pkg;

    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic        valid;
        logic        yumi;
        logic [31:0] read_data;
    } mem_out_s;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dmem_state_e;

    localparam int word_bytes_lp = 4;
    localparam int cnt_width_lp  = 3;

    // Byte accesses touch one lane (little-endian), word accesses all four.
    function automatic logic [3:0] lane_mask(input logic byte_not_word, input logic [1:0] lane);
        lane_mask = byte_not_word ? (4'b0001 << lane) : 4'b1111;
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// Core <-> data memory bus: request struct, byte address and response struct.
interface data_mem_if;
    import data_mem_pkg::*;

    mem_in_s     to_mem_i;
    logic [31:0] addr_i;
    mem_out_s    from_mem_o;

    modport master (output to_mem_i, output addr_i, input from_mem_o);
    modport slave  (input to_mem_i, input addr_i, output from_mem_o);
endinterface

// File: rtl/data_ram.sv
// Word-organised storage: synchronous byte-enabled write, asynchronous read.
module data_ram
    import data_mem_pkg::*;
#(
    parameter int addr_width_p = 10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [3:0]              be,
    input  logic [addr_width_p-1:0] addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata
);

    logic [31:0] mem [2**addr_width_p];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < word_bytes_lp; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem.sv
// Fixed-latency data memory controller: accepts one request, waits latency_p
// cycles, performs the access and holds the response until the core takes it.
//
// state | meaning
// IDLE  | ready; yumi mirrors request valid
// BUSY  | request latched, latency counter running down
// RESP  | access done, response held until core yumi
module data_mem
    import data_mem_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic       clk,
    input  logic       reset,
    data_mem_if.slave  mem_bus
);

    dmem_state_e             state_r, state_n;
    logic [cnt_width_lp-1:0] cnt_r, cnt_n;
    logic [addr_width_p+1:0] addr_r;
    logic [31:0]             wdata_r;
    logic                    wen_r;
    logic                    bnw_r;
    logic [31:0]             resp_r, resp_n;
    logic                    accept;
    logic                    access;

    logic                    ram_we;
    logic [3:0]              ram_be;
    logic [31:0]             ram_wdata;
    logic [31:0]             ram_rdata;
    logic [31:0]             load_data;
    logic [1:0]              lane;

    // Address bits above the storage size wrap silently.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_bus.addr_i[31:addr_width_p+2];

    assign lane = addr_r[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
            wen_r   <= 1'b0;
            bnw_r   <= 1'b0;
            resp_r  <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            resp_r  <= resp_n;
            if (accept) begin
                addr_r  <= mem_bus.addr_i[addr_width_p+1:0];
                wdata_r <= mem_bus.to_mem_i.write_data;
                wen_r   <= mem_bus.to_mem_i.wen;
                bnw_r   <= mem_bus.to_mem_i.byte_not_word;
            end
        end
    end

    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        resp_n  = resp_r;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_bus.to_mem_i.valid) begin
                    accept  = 1'b1;
                    cnt_n   = cnt_width_lp'(latency_p - 1);
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (cnt_r == '0) begin
                    access  = 1'b1;
                    resp_n  = wen_r ? '0 : load_data;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt_r - cnt_width_lp'(1);
                end
            end
            RESP: begin
                if (mem_bus.to_mem_i.yumi) begin
                    resp_n  = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Byte stores replicate the byte to every lane; the enable picks one.
    assign ram_we    = access & wen_r;
    assign ram_be    = lane_mask(bnw_r, lane);
    assign ram_wdata = bnw_r ? {4{wdata_r[7:0]}} : wdata_r;
    assign load_data = bnw_r ? {24'b0, ram_rdata[{lane, 3'b000} +: 8]} : ram_rdata;

    data_ram #(
        .addr_width_p (addr_width_p)
    ) u_data_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (addr_r[addr_width_p+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        mem_bus.from_mem_o           = '0;
        mem_bus.from_mem_o.valid     = (state_r == RESP);
        mem_bus.from_mem_o.read_data = (state_r == RESP) ? resp_r : '0;
        mem_bus.from_mem_o.yumi      = (state_r == IDLE) & mem_bus.to_mem_i.valid & ~reset;
    end

endmodule
